mem_request_issuer: RTL and testbench
=====================================

MEM_REQUEST_ISSUER -- requirements
Module: mem_request_issuer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 128, memory entry width.
REQ-003 SHALL have parameter SERIAL_WIDTH, default 4, read/write serial width.
REQ-004 SHALL have parameter TAG_WIDTH, default 2, requester tag width.
REQ-005 SHALL have parameter MAX_RD_OUTSTANDING, default 4, in-flight read limit; power of 2, at most 2^SERIAL_WIDTH.
REQ-006 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-007 SHALL have port rst  input  1  reset; one clock, reset asynchronous and active-low.
REQ-008 SHALL have ports rdReqValid/rdReqReady  in/out  1  read request handshake; rdReqAddr  in  ADDR_WIDTH; rdReqTag  in  TAG_WIDTH.
REQ-009 SHALL have ports wrReqValid/wrReqReady  in/out  1  write request handshake; wrReqAddr  in  ADDR_WIDTH; wrReqData  in  DATA_WIDTH.
REQ-010 SHALL have ports memAccessRE, memAccessWE  out  1; memAccessAddr  out  ADDR_WIDTH; memAccessWriteData  out  DATA_WIDTH; memAccessBusy  in  1  memory not accepting.
REQ-011 SHALL have ports memReadDataReady  in  1; memReadData  in  DATA_WIDTH; memReadSerial  in  SERIAL_WIDTH; memAccessResponseValid  in  1; memAccessResponseSerial  in  SERIAL_WIDTH.
REQ-012 SHALL have ports rdRespValid  out  1; rdRespData  out  DATA_WIDTH; rdRespTag  out  TAG_WIDTH; wrDoneValid  out  1; rdOutstanding  out  SERIAL_WIDTH+1; wrOutstanding  out  SERIAL_WIDTH+1; errUnexpected  out  1  sticky.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE_RD, ISSUE_WR; outputs memAccess* registered.
REQ-014 In IDLE, rdReqReady SHALL be 1 only when the read is granted and rdOutstanding < MAX_RD_OUTSTANDING; wrReqReady SHALL be 1 only when the write is granted; both 0 outside IDLE.
REQ-015 On rdReqValid&&rdReqReady at cycle N, SHALL latch addr/tag and enter ISSUE_RD with memAccessRE=1 at N+1; write analogous with memAccessWE=1, WriteData driven.
REQ-016 Issue SHALL be accepted in the cycle RE/WE=1 and memAccessBusy=0; RE/WE, addr, data SHALL hold stable while busy; next cycle FSM returns to IDLE, RE/WE=0.
REQ-017 RE and WE SHALL never both be 1.
REQ-018 SHALL keep internal rdSerial/wrSerial counters (reset 0, +1 per accepted read/write, wrap modulo 2^SERIAL_WIDTH).
REQ-019 On accepted read, SHALL store tag and valid=1 in table entry rdSerial mod MAX_RD_OUTSTANDING; rdOutstanding +1.
REQ-020 On memReadDataReady, SHALL look up entry memReadSerial mod MAX_RD_OUTSTANDING; if valid: next cycle rdRespValid=1 for exactly one cycle with memReadData and stored tag, entry cleared, rdOutstanding -1.
REQ-021 Response to invalid entry SHALL set errUnexpected, produce no rdRespValid, and leave counters unchanged.
REQ-022 On accepted write, wrOutstanding +1; on memAccessResponseValid, wrDoneValid=1 the next cycle for one cycle and wrOutstanding -1; response with wrOutstanding=0 SHALL set errUnexpected.
REQ-023 Accept and response in the same cycle SHALL leave the matching counter unchanged; same-serial retire and re-allocate SHALL retire the old entry first.
REQ-024 Arbitration SHALL follow REQ-029/REQ-030.

Reset
REQ-025 While rst=0, FSM SHALL be IDLE, all outputs 0, counters 0, table invalid, errUnexpected 0.
REQ-026 Reset asserted mid-issue SHALL immediately drop RE/WE and discard in-flight tracking; responses arriving after release SHALL set errUnexpected.
REQ-027 First issue after release SHALL occur no earlier than the second clk edge after rst rises.

Configuration
REQ-028 Macro MEM_REQUEST_ISSUER_WRITE_PRIORITY_EN SHALL select the arbitration policy.
REQ-029 When defined, a valid write SHALL always win over a valid read in IDLE.
REQ-030 When undefined, arbitration SHALL be round-robin: after a granted write, reads win the next conflict, and vice versa; reset favors read.

Verification
REQ-031 Read addr 0x100 tag 2, busy=0 -> RE=1 one cycle; response serial 0 data 0xAA.. -> rdRespValid, tag 2, data 0xAA.. next cycle.
REQ-032 Write with busy=1 for 3 cycles -> WE/addr/data held 4 cycles; response -> wrDoneValid one cycle, wrOutstanding 1->0.
REQ-033 Five back-to-back reads, no responses -> four issued, rdReqReady=0, rdOutstanding=4; one response -> fifth issues.
REQ-034 Simultaneous read+write valid, both macro settings -> write first (defined); alternating R,W,R,W grant (undefined).
REQ-035 memReadDataReady with unused serial 3 -> errUnexpected=1, no rdRespValid, sticky until reset.
REQ-036 17 sequential read/response pairs (SERIAL_WIDTH=4) -> serial wraps 15->0, all tags correct.

Source files
------------

// File: rtl/mem_request_issuer.sv
// rtl/mem_request_issuer.sv - arbitrates read/write requests onto a memory port and tracks their completions
//
// Purpose:
//   Accepts read and write requests from a requester, issues them one at a time
//   on a registered memory access port, and matches returning completions:
//   reads against a per-serial tag table, writes against an outstanding count.
//   Unmatched completions raise a sticky errUnexpected flag.
//
// Configuration macro:
//   MEM_REQUEST_ISSUER_WRITE_PRIORITY_EN
//     defined   : a valid write always wins over a valid read.
//     undefined : round-robin between reads and writes; reads win first.
//
// Ports:
//   clk, rst                    clock (posedge) and asynchronous active-low reset
//   rdReqValid/rdReqReady       read request handshake, with rdReqAddr, rdReqTag
//   wrReqValid/wrReqReady       write request handshake, with wrReqAddr, wrReqData
//   memAccessRE/WE/Addr/WriteData  registered memory access request
//   memAccessBusy               memory not accepting the current access
//   memReadDataReady/Data/Serial  read completion from memory
//   memAccessResponseValid/Serial write completion from memory
//   rdRespValid/Data/Tag        one-cycle read response to the requester
//   wrDoneValid                 one-cycle write completion to the requester
//   rdOutstanding/wrOutstanding in-flight read/write counts
//   errUnexpected               sticky: a completion matched nothing in flight
module mem_request_issuer #(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 128,
  parameter int SERIAL_WIDTH       = 4,
  parameter int TAG_WIDTH          = 2,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    rdReqValid,
  output logic                    rdReqReady,
  input  logic [ADDR_WIDTH-1:0]   rdReqAddr,
  input  logic [TAG_WIDTH-1:0]    rdReqTag,

  input  logic                    wrReqValid,
  output logic                    wrReqReady,
  input  logic [ADDR_WIDTH-1:0]   wrReqAddr,
  input  logic [DATA_WIDTH-1:0]   wrReqData,

  output logic                    memAccessRE,
  output logic                    memAccessWE,
  output logic [ADDR_WIDTH-1:0]   memAccessAddr,
  output logic [DATA_WIDTH-1:0]   memAccessWriteData,
  input  logic                    memAccessBusy,

  input  logic                    memReadDataReady,
  input  logic [DATA_WIDTH-1:0]   memReadData,
  input  logic [SERIAL_WIDTH-1:0] memReadSerial,
  input  logic                    memAccessResponseValid,
  input  logic [SERIAL_WIDTH-1:0] memAccessResponseSerial,

  output logic                    rdRespValid,
  output logic [DATA_WIDTH-1:0]   rdRespData,
  output logic [TAG_WIDTH-1:0]    rdRespTag,
  output logic                    wrDoneValid,
  output logic [SERIAL_WIDTH:0]   rdOutstanding,
  output logic [SERIAL_WIDTH:0]   wrOutstanding,
  output logic                    errUnexpected
);

  // Table index is the low bits of the serial (serial mod MAX_RD_OUTSTANDING).
  // A limit of 1 still gets a 1-bit index; the outstanding limit keeps it correct.
  localparam int IDX_W     = (MAX_RD_OUTSTANDING > 1) ? $clog2(MAX_RD_OUTSTANDING) : 1;
  localparam int TBL_DEPTH = 1 << IDX_W;

  localparam logic [SERIAL_WIDTH:0]   RD_LIMIT = (SERIAL_WIDTH+1)'(MAX_RD_OUTSTANDING);
  localparam logic [SERIAL_WIDTH:0]   CNT_ONE  = (SERIAL_WIDTH+1)'(1);
  localparam logic [SERIAL_WIDTH-1:0] SER_ONE  = SERIAL_WIDTH'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ISSUE_RD = 2'd1;
  localparam logic [1:0] ISSUE_WR = 2'd2;

  logic [1:0]              state;
  logic [TAG_WIDTH-1:0]    pendTag;
  logic [SERIAL_WIDTH-1:0] rdSerial;
  logic [SERIAL_WIDTH-1:0] wrSerial;

  logic [TBL_DEPTH-1:0]    tblValid;
  logic [TAG_WIDTH-1:0]    tblTag [TBL_DEPTH];

  logic                    rdElig;
  logic                    grantRd;
  logic                    grantWr;
  logic                    rdHs;
  logic                    wrHs;
  logic                    rdIssueAcc;
  logic                    wrIssueAcc;
  logic [IDX_W-1:0]        allocIdx;
  logic [IDX_W-1:0]        rspIdx;
  logic                    rspHit;
  logic                    rspMiss;
  logic                    wrRspOk;
  logic                    wrRspMiss;

  // Serials are carried for the memory's benefit; only their low bits index
  // the read table and the write side matches by count alone.
  logic                    unusedSink;
  assign unusedSink = ^{memReadSerial, memAccessResponseSerial, wrSerial};

  // ---------------------------------------------------------------------------
  // Arbitration. A read that would exceed the in-flight limit is not eligible,
  // so a waiting write is not blocked behind a read that cannot go anyway.
  // ---------------------------------------------------------------------------
  assign rdElig = rdReqValid && (rdOutstanding < RD_LIMIT);

`ifdef MEM_REQUEST_ISSUER_WRITE_PRIORITY_EN
  always_comb begin
    grantWr = wrReqValid;
    grantRd = rdElig && !wrReqValid;
  end
`else
  // favorRd: which side wins the next read/write conflict.
  logic favorRd;

  always_comb begin
    grantRd = rdElig;
    grantWr = wrReqValid;
    if (rdElig && wrReqValid) begin
      grantRd = favorRd;
      grantWr = !favorRd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      favorRd <= 1'b1;
    end else if (rdHs) begin
      favorRd <= 1'b0;
    end else if (wrHs) begin
      favorRd <= 1'b1;
    end
  end
`endif

  // Ready is gated by rst so that nothing handshakes while reset is held.
  assign rdReqReady = rst && (state == IDLE) && grantRd;
  assign wrReqReady = rst && (state == IDLE) && grantWr;

  assign rdHs       = rdReqValid && rdReqReady;
  assign wrHs       = wrReqValid && wrReqReady;
  assign rdIssueAcc = (state == ISSUE_RD) && !memAccessBusy;
  assign wrIssueAcc = (state == ISSUE_WR) && !memAccessBusy;

  // ---------------------------------------------------------------------------
  // Issue FSM: a handshake loads the registered access; it stays put until the
  // memory takes it (busy low), then the FSM drops back to IDLE.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      memAccessRE        <= 1'b0;
      memAccessWE        <= 1'b0;
      memAccessAddr      <= '0;
      memAccessWriteData <= '0;
      pendTag            <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rdHs) begin
            state         <= ISSUE_RD;
            memAccessRE   <= 1'b1;
            memAccessAddr <= rdReqAddr;
            pendTag       <= rdReqTag;
          end else if (wrHs) begin
            state              <= ISSUE_WR;
            memAccessWE        <= 1'b1;
            memAccessAddr      <= wrReqAddr;
            memAccessWriteData <= wrReqData;
          end
        end
        ISSUE_RD: begin
          if (!memAccessBusy) begin
            state       <= IDLE;
            memAccessRE <= 1'b0;
          end
        end
        ISSUE_WR: begin
          if (!memAccessBusy) begin
            state       <= IDLE;
            memAccessWE <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          memAccessRE <= 1'b0;
          memAccessWE <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read tracking table
  // ---------------------------------------------------------------------------
  assign allocIdx = rdSerial[IDX_W-1:0];
  assign rspIdx   = memReadSerial[IDX_W-1:0];
  assign rspHit   = memReadDataReady && tblValid[rspIdx];
  assign rspMiss  = memReadDataReady && !tblValid[rspIdx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tblValid      <= '0;
      for (int i = 0; i < TBL_DEPTH; i++) begin
        tblTag[i] <= '0;
      end
      rdSerial      <= '0;
      rdOutstanding <= '0;
      rdRespValid   <= 1'b0;
      rdRespData    <= '0;
      rdRespTag     <= '0;
    end else begin
      rdRespValid <= rspHit;
      if (rspHit) begin
        rdRespData       <= memReadData;
        rdRespTag        <= tblTag[rspIdx];
        tblValid[rspIdx] <= 1'b0;
      end
      // Placed after the retire so a same-index allocation in the same cycle
      // wins: the old entry is retired first, then the slot is reused.
      if (rdIssueAcc) begin
        tblValid[allocIdx] <= 1'b1;
        tblTag[allocIdx]   <= pendTag;
        rdSerial           <= rdSerial + SER_ONE;
      end
      case ({rdIssueAcc, rspHit})
        2'b10:   rdOutstanding <= rdOutstanding + CNT_ONE;
        2'b01:   rdOutstanding <= rdOutstanding - CNT_ONE;
        default: rdOutstanding <= rdOutstanding;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write tracking. A completion with nothing outstanding is an error and does
  // not produce wrDoneValid.
  // ---------------------------------------------------------------------------
  assign wrRspOk   = memAccessResponseValid && (wrOutstanding != '0);
  assign wrRspMiss = memAccessResponseValid && (wrOutstanding == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrSerial      <= '0;
      wrOutstanding <= '0;
      wrDoneValid   <= 1'b0;
    end else begin
      wrDoneValid <= wrRspOk;
      if (wrIssueAcc) begin
        wrSerial <= wrSerial + SER_ONE;
      end
      case ({wrIssueAcc, wrRspOk})
        2'b10:   wrOutstanding <= wrOutstanding + CNT_ONE;
        2'b01:   wrOutstanding <= wrOutstanding - CNT_ONE;
        default: wrOutstanding <= wrOutstanding;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      errUnexpected <= 1'b0;
    end else if (rspMiss || wrRspMiss) begin
      errUnexpected <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_request_issuer.sv
// tb/tb_mem_request_issuer.sv - randomized scoreboard bench for mem_request_issuer
`timescale 1ns/1ps
module tb_mem_request_issuer;
  localparam int AW    = 32;
  localparam int DW    = 128;
  localparam int SW    = 4;
  localparam int TW    = 2;
  localparam int MAXRD = 4;
  localparam int NSER  = 1 << SW;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          rdReqValid, rdReqReady;
  logic [AW-1:0] rdReqAddr;
  logic [TW-1:0] rdReqTag;
  logic          wrReqValid, wrReqReady;
  logic [AW-1:0] wrReqAddr;
  logic [DW-1:0] wrReqData;
  logic          memAccessRE, memAccessWE;
  logic [AW-1:0] memAccessAddr;
  logic [DW-1:0] memAccessWriteData;
  logic          memAccessBusy;
  logic          memReadDataReady;
  logic [DW-1:0] memReadData;
  logic [SW-1:0] memReadSerial;
  logic          memAccessResponseValid;
  logic [SW-1:0] memAccessResponseSerial;
  logic          rdRespValid;
  logic [DW-1:0] rdRespData;
  logic [TW-1:0] rdRespTag;
  logic          wrDoneValid;
  logic [SW:0]   rdOutstanding, wrOutstanding;
  logic          errUnexpected;

  mem_request_issuer dut (
    .clk(clk), .rst(rst),
    .rdReqValid(rdReqValid), .rdReqReady(rdReqReady), .rdReqAddr(rdReqAddr), .rdReqTag(rdReqTag),
    .wrReqValid(wrReqValid), .wrReqReady(wrReqReady), .wrReqAddr(wrReqAddr), .wrReqData(wrReqData),
    .memAccessRE(memAccessRE), .memAccessWE(memAccessWE), .memAccessAddr(memAccessAddr),
    .memAccessWriteData(memAccessWriteData), .memAccessBusy(memAccessBusy),
    .memReadDataReady(memReadDataReady), .memReadData(memReadData), .memReadSerial(memReadSerial),
    .memAccessResponseValid(memAccessResponseValid), .memAccessResponseSerial(memAccessResponseSerial),
    .rdRespValid(rdRespValid), .rdRespData(rdRespData), .rdRespTag(rdRespTag),
    .wrDoneValid(wrDoneValid), .rdOutstanding(rdOutstanding), .wrOutstanding(wrOutstanding),
    .errUnexpected(errUnexpected)
  );

  always #5 clk = ~clk;

  typedef struct packed { int serial; logic [TW-1:0] tag; } rdEntry_t;
  typedef struct packed { logic [TW-1:0] tag; logic [DW-1:0] data; } rdExp_t;

  // Reference model: reads in flight (in issue order), pending expectations.
  rdEntry_t      rdQ[$];
  rdExp_t        rdExpQ[$];
  int            wrExpQ[$];
  int            wrSerQ[$];
  int            wrCount;
  int            rdSerNext, wrSerNext;
  bit            active, isWr, favorRead, modelErr, rdHs, wrHs, allowNew;
  logic [AW-1:0] issAddr;
  logic [DW-1:0] issData;
  logic [TW-1:0] issTag;
  rdExp_t        monE;

  int nChecks = 0;
  int nPass   = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic modelReset();
    rdQ.delete(); rdExpQ.delete(); wrExpQ.delete(); wrSerQ.delete();
    wrCount = 0; rdSerNext = 0; wrSerNext = 0;
    active = 0; isWr = 0; favorRead = 1; modelErr = 0; rdHs = 0; wrHs = 0;
  endtask

  // Runs at the falling edge: compare current outputs against the model, then
  // advance the model by what the next rising edge will do.
  task automatic checkAndModel();
    bit rdOk, expRd, expWr;
    int hitPos;
    rdExp_t e;
    if (!rst) begin
      check("rstRE", memAccessRE, 0);
      check("rstWE", memAccessWE, 0);
      check("rstAddr", memAccessAddr, 0);
      check("rstRdRdy", rdReqReady, 0);
      check("rstWrRdy", wrReqReady, 0);
      check("rstRdResp", rdRespValid, 0);
      check("rstWrDone", wrDoneValid, 0);
      check("rstRdOut", rdOutstanding, 0);
      check("rstWrOut", wrOutstanding, 0);
      check("rstErr", errUnexpected, 0);
      return;
    end
    rdOk  = rdReqValid && (rdQ.size() < MAXRD);
    expRd = 0;
    expWr = 0;
    if (!active) begin
`ifdef MEM_REQUEST_ISSUER_WRITE_PRIORITY_EN
      expWr = wrReqValid;
      expRd = rdOk && !wrReqValid;
`else
      if (rdOk && wrReqValid) begin
        expRd = favorRead;
        expWr = !favorRead;
      end else begin
        expRd = rdOk;
        expWr = wrReqValid;
      end
`endif
    end
    check("rdReqReady", rdReqReady, expRd);
    check("wrReqReady", wrReqReady, expWr);
    check("memAccessRE", memAccessRE, active && !isWr);
    check("memAccessWE", memAccessWE, active && isWr);
    if (active) check("memAccessAddr", memAccessAddr, issAddr);
    if (active && isWr) check("memAccessWriteData", memAccessWriteData, issData);
    check("rdOutstanding", rdOutstanding, rdQ.size());
    check("wrOutstanding", wrOutstanding, wrCount);
    check("errUnexpected", errUnexpected, modelErr);

    // Completions are judged against what was in flight before this edge.
    if (memReadDataReady) begin
      hitPos = -1;
      foreach (rdQ[i]) if ((rdQ[i].serial % MAXRD) == (memReadSerial % MAXRD)) hitPos = i;
      if (hitPos < 0) modelErr = 1;
      else begin
        e.tag  = rdQ[hitPos].tag;
        e.data = memReadData;
        rdExpQ.push_back(e);
        rdQ.delete(hitPos);
      end
    end
    if (memAccessResponseValid) begin
      if (wrCount == 0) modelErr = 1;
      else begin
        wrExpQ.push_back(int'(memAccessResponseSerial));
        wrCount--;
        void'(wrSerQ.pop_front());
      end
    end
    if (active && !memAccessBusy) begin
      if (isWr) begin
        wrCount++;
        wrSerQ.push_back(wrSerNext);
        wrSerNext = (wrSerNext + 1) % NSER;
      end else begin
        rdQ.push_back('{serial: rdSerNext, tag: issTag});
        rdSerNext = (rdSerNext + 1) % NSER;
      end
      active = 0;
    end
    rdHs = rdReqValid && expRd;
    wrHs = wrReqValid && expWr;
    if (rdHs) begin
      active = 1; isWr = 0; issAddr = rdReqAddr; issTag = rdReqTag; favorRead = 0;
    end else if (wrHs) begin
      active = 1; isWr = 1; issAddr = wrReqAddr; issData = wrReqData; favorRead = 1;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkAndModel();
    @(posedge clk);
    #1;
  endtask

  // Random requester + memory behaviour for one cycle.
  task automatic driveRandom(input int rspPct);
    if (!rdReqValid || rdHs) begin
      rdReqValid = allowNew && ($urandom_range(0, 2) != 0);
      rdReqAddr  = $urandom;
      rdReqTag   = TW'($urandom);
    end
    if (!wrReqValid || wrHs) begin
      wrReqValid = allowNew && ($urandom_range(0, 1) != 0);
      wrReqAddr  = $urandom;
      wrReqData  = {$urandom, $urandom, $urandom, $urandom};
    end
    memAccessBusy = ($urandom_range(0, 3) == 0);
    memReadData   = {$urandom, $urandom, $urandom, $urandom};
    memReadDataReady = (rdQ.size() > 0) && ($urandom_range(0, 99) < rspPct);
    memReadSerial    = (rdQ.size() > 0) ? SW'(rdQ[0].serial) : SW'($urandom);
    memAccessResponseValid  = (wrCount > 0) && ($urandom_range(0, 99) < rspPct);
    memAccessResponseSerial = (wrCount > 0) ? SW'(wrSerQ[0]) : SW'($urandom);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst && rdRespValid) begin
      if (rdExpQ.size() == 0) check("rdRespSpurious", rdRespValid, 0);
      else begin
        monE = rdExpQ.pop_front();
        check("rdRespTag", rdRespTag, monE.tag);
        check("rdRespData", rdRespData, monE.data);
      end
    end
    if (rst && wrDoneValid) begin
      if (wrExpQ.size() == 0) check("wrDoneSpurious", wrDoneValid, 0);
      else void'(wrExpQ.pop_front());
    end
  end

  initial begin
    bit drained;
    rdReqValid = 0; rdReqAddr = '0; rdReqTag = '0;
    wrReqValid = 0; wrReqAddr = '0; wrReqData = '0;
    memAccessBusy = 0; memReadDataReady = 0; memReadData = '0; memReadSerial = '0;
    memAccessResponseValid = 0; memAccessResponseSerial = '0;
    allowNew = 1;
    modelReset();

    // Reset: outputs stay zero even with requests offered.
    stepCycle();
    rdReqValid = 1; wrReqValid = 1;
    stepCycle();
    rdReqValid = 0; wrReqValid = 0;
    rst = 1;

    // Randomized traffic with slow-ish completions so the read limit is hit.
    for (int cyc = 0; cyc < 700; cyc++) begin
      driveRandom(25);
      stepCycle();
    end

    // Drain everything in flight.
    allowNew = 0;
    drained  = 0;
    for (int cyc = 0; cyc < 300 && !drained; cyc++) begin
      driveRandom(100);
      stepCycle();
      drained = !active && rdQ.size() == 0 && wrCount == 0 && !rdReqValid && !wrReqValid;
    end
    memReadDataReady = 0; memAccessResponseValid = 0; memAccessBusy = 0;
    stepCycle();
    stepCycle();
    check("drainDone", drained, 1);
    check("rdExpEmpty", rdExpQ.size(), 0);
    check("wrExpEmpty", wrExpQ.size(), 0);
    check("serialWrapped", rdSerNext != 0 || rdOutstanding == 0, 1);

    // Completion for a serial that was never issued.
    memReadDataReady = 1; memReadSerial = 4'd3; memReadData = {4{32'hdeadbeef}};
    stepCycle();
    memReadDataReady = 0;
    repeat (3) stepCycle();
    check("errStickyRd", errUnexpected, 1);
    memAccessResponseValid = 1;
    stepCycle();
    memAccessResponseValid = 0;
    stepCycle();

    // Clean reset, then reset while a second read is held by busy.
    rst = 0;
    modelReset();
    stepCycle();
    stepCycle();
    rst = 1;
    rdReqValid = 1; rdReqAddr = 32'h100; rdReqTag = 2'd2; memAccessBusy = 0;
    stepCycle();
    rdReqAddr = 32'h200; rdReqTag = 2'd1;
    stepCycle();
    memAccessBusy = 1;
    stepCycle();
    rdReqValid = 0;
    stepCycle();
    check("preResetRdOut", rdOutstanding, 1);
    #2 rst = 0;
    #1;
    check("midResetRE", memAccessRE, 0);
    check("midResetRdOut", rdOutstanding, 0);
    modelReset();
    stepCycle();
    memAccessBusy = 0;
    rst = 1;
    stepCycle();
    memReadDataReady = 1; memReadSerial = '0; memReadData = {4{32'haaaaaaaa}};
    stepCycle();
    memReadDataReady = 0;
    stepCycle();
    stepCycle();
    check("errAfterResetRsp", errUnexpected, 1);
    check("rdExpEmptyEnd", rdExpQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
